// File: rtl/pwm_ramp_sequencer_if.sv
// Control/status bundle between the SPI register file / PWM peripheral and the duty ramp sequencer.
interface pwm_ramp_sequencer_if #(
  parameter int DIV_W  = 8,
  parameter int STEP_W = 4
);
  logic              ramp_en;
  logic [7:0]        target_duty;
  logic [STEP_W-1:0] step_size;
  logic [DIV_W-1:0]  step_div;
  logic              period_end;
  logic [7:0]        duty_out;
  logic              busy;
  logic              done;
  logic              dir;

  modport master (
    output ramp_en, target_duty, step_size, step_div, period_end,
    input  duty_out, busy, done, dir
  );

  modport slave (
    input  ramp_en, target_duty, step_size, step_div, period_end,
    output duty_out, busy, done, dir
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Ramps the applied PWM duty toward a target in bounded steps, updating only on PWM period boundaries.
module pwm_ramp_sequencer #(
  parameter int DIV_W  = 8,
  parameter int STEP_W = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pwm_ramp_sequencer_if.slave    io
);
  localparam int AW = (STEP_W > 9) ? STEP_W : 9;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [7:0]       duty;
  logic             busy_q;
  logic             done_q;
  logic             dir_q;

  logic [AW-1:0]    s;
  logic [AW-1:0]    diff;
  logic [AW-1:0]    inc;
  logic             up;
  logic [7:0]       stepped;
  logic             step_now;

  assign io.duty_out = duty;
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.dir      = dir_q;

  // Step is clamped to the remaining distance, so it can neither overshoot nor wrap.
  always_comb begin
    s = AW'(io.step_size);
    if (io.step_size == '0) s = AW'(1);
    up   = io.target_duty > duty;
    diff = up ? AW'(io.target_duty) - AW'(duty) : AW'(duty) - AW'(io.target_duty);
    inc  = (s < diff) ? s : diff;
    stepped = up ? 8'(AW'(duty) + inc) : 8'(AW'(duty) - inc);
    step_now = io.period_end && (cnt == io.step_div);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      duty   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (io.period_end) duty <= io.target_duty;
          if (io.ramp_en) begin
            if (io.target_duty != duty) begin
              state  <= RAMP;
              busy_q <= 1'b1;
            end else begin
              state  <= HOLD;
            end
          end
        end
        RAMP: begin
          // A period_end arriving with the exit is still serviced as a RAMP step.
          if (io.period_end) begin
            if (step_now) begin
              cnt <= '0;
              if (io.target_duty != duty) begin
                duty  <= stepped;
                dir_q <= up;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (!io.ramp_en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
          end else if (io.target_duty == duty) begin
            state  <= HOLD;
            busy_q <= 1'b0;
          end else if (step_now && stepped == io.target_duty) begin
            state  <= HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!io.ramp_en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (io.target_duty != duty) begin
            state  <= RAMP;
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed vector bench for pwm_ramp_sequencer: table of per-cycle vectors plus hand-written corner sequences.
module tb_pwm_ramp_sequencer;
  logic clk;
  logic rst_n;

  pwm_ramp_sequencer_if #(.DIV_W(8), .STEP_W(4)) bus ();

  pwm_ramp_sequencer #(.DIV_W(8), .STEP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       re;
    logic [7:0] t;
    logic [3:0] ss;
    logic [7:0] sd;
    logic       pe;
    logic [7:0] duty;
    logic       busy;
    logic       done;
    logic       dir;
  } vec_t;

  vec_t vt[$];
  int   vectors;
  int   miscompares;

  function automatic void add(input logic re, input logic [7:0] t, input logic [3:0] ss,
                              input logic [7:0] sd, input logic pe, input logic [7:0] duty,
                              input logic busy, input logic done, input logic dir);
    vec_t v;
    v.re = re; v.t = t; v.ss = ss; v.sd = sd; v.pe = pe;
    v.duty = duty; v.busy = busy; v.done = done; v.dir = dir;
    vt.push_back(v);
  endfunction

  task automatic drive(input logic re, input logic [7:0] t, input logic [3:0] ss,
                       input logic [7:0] sd, input logic pe);
    bus.ramp_en     = re;
    bus.target_duty = t;
    bus.step_size   = ss;
    bus.step_div    = sd;
    bus.period_end  = pe;
  endtask

  task automatic check(input string name, input logic [7:0] duty, input logic busy,
                       input logic done, input logic dir);
    vectors++;
    if (bus.duty_out !== duty || bus.busy !== busy || bus.done !== done || bus.dir !== dir) begin
      miscompares++;
      $display("FAIL %s: got duty=%h busy=%b done=%b dir=%b, expected duty=%h busy=%b done=%b dir=%b",
               name, bus.duty_out, bus.busy, bus.done, bus.dir, duty, busy, done, dir);
    end
  endtask

  // One clock: drive at the falling edge, check at the next falling edge.
  task automatic cyc(input string name, input logic re, input logic [7:0] t, input logic [3:0] ss,
                     input logic [7:0] sd, input logic pe, input logic [7:0] duty,
                     input logic busy, input logic done, input logic dir);
    drive(re, t, ss, sd, pe);
    @(negedge clk);
    check(name, duty, busy, done, dir);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;

    // bypass mode: duty follows target only on period_end
    add(0, 8'h80, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 8'h80, 0, 0, 1, 8'h80, 0, 0, 0);
    add(0, 8'h10, 0, 0, 0, 8'h80, 0, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0);
    // ramp up 0 -> 0x10, step 4, every 2nd period_end
    add(1, 8'h10, 4, 1, 0, 8'h00, 1, 0, 0);
    add(1, 8'h10, 4, 1, 1, 8'h00, 1, 0, 0);
    add(1, 8'h10, 4, 1, 0, 8'h00, 1, 0, 0);
    add(1, 8'h10, 4, 1, 1, 8'h04, 1, 0, 1);
    add(1, 8'h10, 4, 1, 1, 8'h04, 1, 0, 1);
    add(1, 8'h10, 4, 1, 1, 8'h08, 1, 0, 1);
    add(1, 8'h10, 4, 1, 1, 8'h08, 1, 0, 1);
    add(1, 8'h10, 4, 1, 1, 8'h0C, 1, 0, 1);
    add(1, 8'h10, 4, 1, 1, 8'h0C, 1, 0, 1);
    add(1, 8'h10, 4, 1, 1, 8'h10, 0, 1, 1);
    add(1, 8'h10, 4, 1, 0, 8'h10, 0, 0, 1);
    // back to bypass to preload 0x0A, then ramp down to 0 without underflow
    add(0, 8'h0A, 4, 1, 0, 8'h10, 0, 0, 1);
    add(0, 8'h0A, 4, 1, 1, 8'h0A, 0, 0, 1);
    add(1, 8'h00, 4, 0, 0, 8'h0A, 1, 0, 1);
    add(1, 8'h00, 4, 0, 1, 8'h06, 1, 0, 0);
    add(1, 8'h00, 4, 0, 1, 8'h02, 1, 0, 0);
    add(1, 8'h00, 4, 0, 1, 8'h00, 0, 1, 0);
    add(1, 8'h00, 4, 0, 0, 8'h00, 0, 0, 0);
    // ramp up by 8 toward 0x28, redirect at 0x20 to 0x18
    add(1, 8'h28, 8, 0, 0, 8'h00, 1, 0, 0);
    add(1, 8'h28, 8, 0, 1, 8'h08, 1, 0, 1);
    add(1, 8'h28, 8, 0, 1, 8'h10, 1, 0, 1);
    add(1, 8'h28, 8, 0, 1, 8'h18, 1, 0, 1);
    add(1, 8'h28, 8, 0, 1, 8'h20, 1, 0, 1);
    add(1, 8'h18, 8, 0, 1, 8'h18, 0, 1, 0);
    add(1, 8'h18, 8, 0, 0, 8'h18, 0, 0, 0);
    // target moved back onto duty mid-ramp: HOLD without done
    add(1, 8'h30, 8, 3, 0, 8'h18, 1, 0, 0);
    add(1, 8'h18, 8, 3, 0, 8'h18, 0, 0, 0);

    drive(0, 8'h00, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 8'h00, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].re, vt[i].t, vt[i].ss, vt[i].sd, vt[i].pe);
      @(negedge clk);
      check($sformatf("vec%0d", i), vt[i].duty, vt[i].busy, vt[i].done, vt[i].dir);
    end

    // ramp_en dropped mid-ramp at 0x30 toward 0x90
    cyc("drop_start",  1, 8'h90, 8, 0, 0, 8'h18, 1, 0, 0);
    cyc("drop_s1",     1, 8'h90, 8, 0, 1, 8'h20, 1, 0, 1);
    cyc("drop_s2",     1, 8'h90, 8, 0, 1, 8'h28, 1, 0, 1);
    cyc("drop_s3",     1, 8'h90, 8, 0, 1, 8'h30, 1, 0, 1);
    cyc("drop_idle",   0, 8'h90, 8, 0, 0, 8'h30, 0, 0, 1);
    cyc("drop_wait",   0, 8'h90, 8, 0, 0, 8'h30, 0, 0, 1);
    cyc("drop_jump",   0, 8'h90, 8, 0, 1, 8'h90, 0, 0, 1);

    // asynchronous reset mid-ramp, then a step_size=0 ramp
    cyc("rst_ramp",    1, 8'hF0, 0, 0, 0, 8'h90, 1, 0, 1);
    cyc("rst_step",    1, 8'hF0, 0, 0, 1, 8'h91, 1, 0, 1);
    #3 rst_n = 1'b0;
    #1 check("rst_async", 8'h00, 0, 0, 0);
    bus.period_end = 1'b1;
    @(negedge clk);
    check("rst_pe_ign1", 8'h00, 0, 0, 0);
    @(negedge clk);
    check("rst_pe_ign2", 8'h00, 0, 0, 0);
    bus.period_end = 1'b0;
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ramp", 8'h00, 1, 0, 0);
    cyc("rel_nope",    1, 8'hF0, 0, 0, 0, 8'h00, 1, 0, 0);
    cyc("ss0_step1",   1, 8'hF0, 0, 0, 1, 8'h01, 1, 0, 1);
    cyc("ss0_step2",   1, 8'hF0, 0, 0, 1, 8'h02, 1, 0, 1);

    // exit with coincident period_end is still a RAMP step; then clamp at top of range
    cyc("exit_pe",     0, 8'hF8, 0, 0, 1, 8'h03, 0, 0, 1);
    cyc("bypass_f8",   0, 8'hF8, 0, 0, 1, 8'hF8, 0, 0, 1);
    cyc("top_ramp",    1, 8'hFF, 15, 0, 0, 8'hF8, 1, 0, 1);
    cyc("top_clamp",   1, 8'hFF, 15, 0, 1, 8'hFF, 0, 1, 1);
    cyc("top_hold",    1, 8'hFF, 15, 0, 1, 8'hFF, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_sequencer.md
PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 Parameter DIV_W, default 8: width of the step-divider field and counter.
REQ-002 Parameter STEP_W, default 4: width of the step-size field.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ramp_en  input  1  1 = ramp toward target; 0 = bypass, apply target directly.
REQ-006 target_duty  input  8  requested duty cycle, as held in the SPI register file.
REQ-007 step_size  input  STEP_W  duty increment per step; 0 SHALL be treated as 1.
REQ-008 step_div  input  DIV_W  PWM periods per step is step_div+1.
REQ-009 period_end  input  1  single-cycle pulse from the PWM peripheral on its period wrap.
REQ-010 duty_out  output  8  applied duty cycle, fed to the PWM peripheral's duty input.
REQ-011 busy  output  1  high while in RAMP.
REQ-012 done  output  1  one-cycle pulse when a ramp reaches its target.
REQ-013 dir  output  1  direction of the last step: 1 = up, 0 = down.

Function
REQ-014 duty_out SHALL change only in the cycle after a period_end pulse, which makes PWM updates glitch-free.
REQ-015 The FSM SHALL have exactly three states: IDLE, RAMP and HOLD.
REQ-016 IDLE: ramp_en=0. On each period_end, duty_out <= target_duty. busy=0. The divider counter is held at 0.
REQ-017 IDLE -> RAMP when ramp_en=1 and target_duty != duty_out.
REQ-018 IDLE -> HOLD when ramp_en=1 and target_duty == duty_out.
REQ-019 In RAMP, the divider counter SHALL increment on each period_end.
REQ-020 In RAMP, a period_end with counter == step_div SHALL perform one step and clear the counter to 0.
REQ-021 Step arithmetic SHALL use 9-bit unsigned values, with s = max(step_size,1).
REQ-022 If target_duty > duty_out, duty_out <= duty_out + min(s, target_duty - duty_out) and dir <= 1.
REQ-023 If target_duty < duty_out, duty_out <= duty_out - min(s, duty_out - target_duty) and dir <= 0.
REQ-024 A step SHALL never overshoot the target and SHALL never wrap past 0 or 255.
REQ-025 target_duty SHALL be sampled live at each step; a mid-ramp target change redirects the ramp without restarting the counter.
REQ-026 When a step makes duty_out equal target_duty: RAMP -> HOLD, and done pulses high for one cycle, coincident with the updated duty_out.
REQ-027 If target_duty changes to equal duty_out while in RAMP, RAMP -> HOLD on the next clock with no done pulse.
REQ-028 HOLD: busy=0. HOLD -> RAMP on the clock after target_duty != duty_out is seen, with the counter cleared.
REQ-029 In RAMP or HOLD, ramp_en=0 SHALL force a transition to IDLE on the next clock.
REQ-030 On that transition, the counter SHALL clear and done SHALL NOT pulse.
REQ-031 After that transition, duty_out SHALL jump to target_duty at the next period_end.
REQ-032 period_end coincident with a state transition SHALL be processed by the pre-transition state.
REQ-033 step_div and step_size SHALL be sampled at the step instant; changing them mid-ramp takes effect from the next comparison.
REQ-034 busy SHALL be a registered output equal to (state == RAMP).

Reset
REQ-035 While rst_n=0: duty_out=0, busy=0, done=0, dir=0, counter=0, state=IDLE; period_end is ignored.
REQ-036 Reset asserted mid-ramp SHALL abort the ramp immediately, with no done pulse.
REQ-037 After release, the first duty_out update SHALL occur no earlier than the first period_end that follows release.

Verification
REQ-038 ramp_en=0, target=0x80, period_end every 256 clk -> duty_out=0x80 one cycle after the first period_end; busy stays 0.
REQ-039 ramp_en=1, duty_out=0, target=0x10, step_size=4, step_div=1 -> duty_out 4,8,12,16 on every 2nd period_end; done pulses once with duty_out=16; then HOLD.
REQ-040 duty_out=0x0A, target=0x00, step_size=4, step_div=0 -> duty_out 6,2,0 on consecutive period_ends (no underflow); dir=0; done pulses once.
REQ-041 Mid-ramp up at 0x20, target changed to 0x18, step_size=8, step_div=0 -> next step gives 0x18 with dir=0; done pulses.
REQ-042 ramp_en dropped mid-ramp at duty 0x30, target 0x90 -> IDLE next clock, no done, duty_out=0x90 after the next period_end.
REQ-043 rst_n pulsed low mid-ramp, asynchronous to clk -> all outputs 0 immediately; no update before the first period_end after release; step_size=0 ramp behaves as step 1.
